pipeline_stall_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage pipeline with data cache. Merges three sources into one consistent set of per-stage write/flush/bubble controls:
- load-use stall from the hazard detection unit
- branch flush from ID
- multi-cycle D-cache miss handling, including a handshake to backing memory

Also provides a miss-latency watchdog and saturating performance counters.

---
 rtl/pipe_ctrl_pkg.sv | 14 +
 rtl/sat_counter.sv | 34 +++
 rtl/pipeline_stall_ctrl.sv | 124 ++++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared state encoding and defaults for the pipeline stall controller
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_MISS_REQ  = 2'd1,
    ST_MISS_WAIT = 2'd2,
    ST_REFILL    = 2'd3
  } state_e;

  localparam int DEF_TIMEOUT = 256;
  localparam int DEF_CNT_W   = 16;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // clear wins over increment; holds at all-ones instead of wrapping
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// rtl/pipeline_stall_ctrl.sv - merges load-use stall, branch flush and D-cache miss
// sequencing into per-stage write/flush/bubble controls, with watchdog and counters
module pipeline_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             hazard_stall_i,
  input  logic             branch_flush_i,
  input  logic             dcache_req_i,
  input  logic             dcache_hit_i,
  input  logic             mem_ack_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_write_o,
  output logic             idex_noop_o,
  output logic             exmem_write_o,
  output logic             memwb_noop_o,
  output logic             mem_req_o,
  output logic             refill_we_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] miss_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam int WD_W = $clog2(TIMEOUT) + 1;

  state_e          state_q;
  logic            timeout_q;
  logic            miss;
  logic [WD_W-1:0] wd_cnt;
  logic            wd_expire;

  assign miss      = dcache_req_i & ~dcache_hit_i;
  assign wd_expire = (wd_cnt == WD_W'(TIMEOUT - 1));

  // Mealy decode in RUN, Moore decode in the miss states
  always_comb begin
    pc_write_o    = 1'b1;
    ifid_write_o  = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_write_o  = 1'b1;
    idex_noop_o   = 1'b0;
    exmem_write_o = 1'b1;
    memwb_noop_o  = 1'b0;
    mem_req_o     = 1'b0;
    refill_we_o   = 1'b0;
    if ((state_q != ST_RUN) || miss) begin
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      idex_write_o  = 1'b0;
      exmem_write_o = 1'b0;
      memwb_noop_o  = 1'b1;
      mem_req_o     = (state_q == ST_MISS_REQ);
      refill_we_o   = (state_q == ST_REFILL);
    end else if (hazard_stall_i) begin
      // branch decision waits until the stalled instruction re-issues
      pc_write_o   = 1'b0;
      ifid_write_o = 1'b0;
      idex_noop_o  = 1'b1;
    end else if (branch_flush_i) begin
      ifid_flush_o = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_RUN;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (miss) state_q <= ST_MISS_REQ;
        end
        ST_MISS_REQ: begin
          state_q <= mem_ack_i ? ST_REFILL : ST_MISS_WAIT;
        end
        ST_MISS_WAIT: begin
          if (mem_ack_i) begin
            state_q <= ST_REFILL;
          end else if (wd_expire) begin
            timeout_q <= 1'b1;
          end
        end
        ST_REFILL: begin
          state_q <= ST_RUN;
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  assign timeout_o = timeout_q;

  sat_counter #(.W(CNT_W)) u_miss_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i ((state_q == ST_RUN) && miss),
    .clr_i (1'b0),
    .cnt_o (miss_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (~pc_write_o),
    .clr_i (1'b0),
    .cnt_o (stall_cnt_o)
  );

  // watchdog only runs while waiting; any other state or an ack restarts it
  sat_counter #(.W(WD_W)) u_watchdog (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (state_q == ST_MISS_WAIT),
    .clr_i ((state_q != ST_MISS_WAIT) || mem_ack_i),
    .cnt_o (wd_cnt)
  );

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb/tb_pipeline_stall_ctrl.sv - directed self-checking bench for pipeline_stall_ctrl
module tb_pipeline_stall_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hazard = 1'b0, flush = 1'b0, dreq = 1'b0, dhit = 1'b0, ack = 1'b0;

  logic        pc_write, ifid_write, ifid_flush, idex_write, idex_noop;
  logic        exmem_write, memwb_noop, mem_req, refill_we, timeout;
  logic [15:0] miss_cnt, stall_cnt;

  logic        s_pc_write, s_ifid_write, s_ifid_flush, s_idex_write, s_idex_noop;
  logic        s_exmem_write, s_memwb_noop, s_mem_req, s_refill_we, s_timeout;
  logic [2:0]  s_miss_cnt, s_stall_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipeline_stall_ctrl #(.TIMEOUT(4), .CNT_W(16)) u_dut (
    .clk_i(clk), .rst_i(rst), .hazard_stall_i(hazard), .branch_flush_i(flush),
    .dcache_req_i(dreq), .dcache_hit_i(dhit), .mem_ack_i(ack),
    .pc_write_o(pc_write), .ifid_write_o(ifid_write), .ifid_flush_o(ifid_flush),
    .idex_write_o(idex_write), .idex_noop_o(idex_noop), .exmem_write_o(exmem_write),
    .memwb_noop_o(memwb_noop), .mem_req_o(mem_req), .refill_we_o(refill_we),
    .timeout_o(timeout), .miss_cnt_o(miss_cnt), .stall_cnt_o(stall_cnt)
  );

  pipeline_stall_ctrl #(.TIMEOUT(256), .CNT_W(3)) u_sat (
    .clk_i(clk), .rst_i(rst), .hazard_stall_i(hazard), .branch_flush_i(flush),
    .dcache_req_i(dreq), .dcache_hit_i(dhit), .mem_ack_i(ack),
    .pc_write_o(s_pc_write), .ifid_write_o(s_ifid_write), .ifid_flush_o(s_ifid_flush),
    .idex_write_o(s_idex_write), .idex_noop_o(s_idex_noop), .exmem_write_o(s_exmem_write),
    .memwb_noop_o(s_memwb_noop), .mem_req_o(s_mem_req), .refill_we_o(s_refill_we),
    .timeout_o(s_timeout), .miss_cnt_o(s_miss_cnt), .stall_cnt_o(s_stall_cnt)
  );

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    hazard = 1'b0; flush = 1'b0; dreq = 1'b0; dhit = 1'b0; ack = 1'b0;
  endtask

  task automatic apply_reset;
    idle_inputs();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (pc_write !== 1'b1) begin n_fail++; $display("FAIL rst_pc_write got %b want 1", pc_write); end
    n_cmp++; if ({ifid_write, idex_write, exmem_write} !== 3'b111) begin n_fail++; $display("FAIL rst_writes got %b want 111", {ifid_write, idex_write, exmem_write}); end
    n_cmp++; if ({ifid_flush, idex_noop, memwb_noop, mem_req, refill_we} !== 5'b0) begin n_fail++; $display("FAIL rst_ctrl got %b want 00000", {ifid_flush, idex_noop, memwb_noop, mem_req, refill_we}); end
    cyc();
    rst = 1'b0;
    dreq = 1'b1; dhit = 1'b0;
    cyc();
    @(negedge clk);
    n_cmp++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rst_pre_mem_req got %b want 1", mem_req); end
    rst = 1'b1;
    #1;
    n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_async_mem_req got %b want 0", mem_req); end
    n_cmp++; if (pc_write !== 1'b0) begin n_fail++; $display("FAIL rst_run_miss_pc got %b want 0", pc_write); end
    dreq = 1'b0;
    #1;
    n_cmp++; if (pc_write !== 1'b1) begin n_fail++; $display("FAIL rst_run_pc got %b want 1", pc_write); end
    n_cmp++; if (miss_cnt !== 16'd0 || stall_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_counters got %0d/%0d want 0/0", miss_cnt, stall_cnt); end
    n_cmp++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL rst_timeout got %b want 0", timeout); end
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_load_use;
    apply_reset();
    hazard = 1'b1; flush = 1'b1;
    @(negedge clk);
    n_cmp++; if ({pc_write, ifid_write} !== 2'b00) begin n_fail++; $display("FAIL lu_pc_ifid got %b want 00", {pc_write, ifid_write}); end
    n_cmp++; if (idex_noop !== 1'b1) begin n_fail++; $display("FAIL lu_idex_noop got %b want 1", idex_noop); end
    n_cmp++; if (ifid_flush !== 1'b0) begin n_fail++; $display("FAIL lu_ifid_flush got %b want 0", ifid_flush); end
    n_cmp++; if ({idex_write, exmem_write, memwb_noop} !== 3'b110) begin n_fail++; $display("FAIL lu_downstream got %b want 110", {idex_write, exmem_write, memwb_noop}); end
    cyc();
    idle_inputs();
    @(negedge clk);
    n_cmp++; if (stall_cnt !== 16'd1) begin n_fail++; $display("FAIL lu_stall_cnt got %0d want 1", stall_cnt); end
    n_cmp++; if (pc_write !== 1'b1) begin n_fail++; $display("FAIL lu_resume_pc got %b want 1", pc_write); end
  endtask

  task automatic test_branch_flush;
    apply_reset();
    flush = 1'b1; ack = 1'b1;
    @(negedge clk);
    n_cmp++; if (ifid_flush !== 1'b1) begin n_fail++; $display("FAIL bf_flush got %b want 1", ifid_flush); end
    n_cmp++; if ({pc_write, ifid_write, idex_write, exmem_write} !== 4'b1111) begin n_fail++; $display("FAIL bf_writes got %b want 1111", {pc_write, ifid_write, idex_write, exmem_write}); end
    n_cmp++; if ({mem_req, refill_we, idex_noop} !== 3'b000) begin n_fail++; $display("FAIL bf_ack_ignored got %b want 000", {mem_req, refill_we, idex_noop}); end
    cyc();
    idle_inputs();
  endtask

  task automatic test_miss_3cycle;
    apply_reset();
    for (int k = 0; k < 7; k++) begin
      dreq = 1'b1; dhit = (k == 6); ack = (k == 4);
      @(negedge clk);
      n_cmp++; if (mem_req !== (k == 1)) begin n_fail++; $display("FAIL m3_mem_req c%0d got %b want %b", k, mem_req, (k == 1)); end
      n_cmp++; if (refill_we !== (k == 5)) begin n_fail++; $display("FAIL m3_refill c%0d got %b want %b", k, refill_we, (k == 5)); end
      n_cmp++; if (pc_write !== (k == 6)) begin n_fail++; $display("FAIL m3_pc_write c%0d got %b want %b", k, pc_write, (k == 6)); end
      cyc();
    end
    idle_inputs();
    @(negedge clk);
    n_cmp++; if (miss_cnt !== 16'd1) begin n_fail++; $display("FAIL m3_miss_cnt got %0d want 1", miss_cnt); end
    n_cmp++; if (stall_cnt !== 16'd6) begin n_fail++; $display("FAIL m3_stall_cnt got %0d want 6", stall_cnt); end
  endtask

  task automatic test_fast_ack;
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      dreq = 1'b1; dhit = (k == 3); ack = (k == 1);
      @(negedge clk);
      n_cmp++; if (mem_req !== (k == 1)) begin n_fail++; $display("FAIL fa_mem_req c%0d got %b want %b", k, mem_req, (k == 1)); end
      n_cmp++; if (refill_we !== (k == 2)) begin n_fail++; $display("FAIL fa_refill c%0d got %b want %b", k, refill_we, (k == 2)); end
      n_cmp++; if (pc_write !== (k == 3)) begin n_fail++; $display("FAIL fa_pc_write c%0d got %b want %b", k, pc_write, (k == 3)); end
      cyc();
    end
    idle_inputs();
    @(negedge clk);
    n_cmp++; if (stall_cnt !== 16'd3) begin n_fail++; $display("FAIL fa_stall_cnt got %0d want 3", stall_cnt); end
  endtask

  task automatic test_miss_priority;
    apply_reset();
    dreq = 1'b1; dhit = 1'b0; hazard = 1'b1; flush = 1'b1;
    @(negedge clk);
    n_cmp++; if ({pc_write, ifid_write, idex_write, exmem_write} !== 4'b0000) begin n_fail++; $display("FAIL mp_freeze got %b want 0000", {pc_write, ifid_write, idex_write, exmem_write}); end
    n_cmp++; if ({idex_noop, ifid_flush} !== 2'b00) begin n_fail++; $display("FAIL mp_noop_flush got %b want 00", {idex_noop, ifid_flush}); end
    n_cmp++; if (memwb_noop !== 1'b1) begin n_fail++; $display("FAIL mp_memwb_noop got %b want 1", memwb_noop); end
    cyc();
    @(negedge clk);
    n_cmp++; if ({mem_req, idex_noop, ifid_flush} !== 3'b100) begin n_fail++; $display("FAIL mp_req_hazard_ignored got %b want 100", {mem_req, idex_noop, ifid_flush}); end
    cyc();
    idle_inputs();
  endtask

  task automatic test_watchdog;
    apply_reset();
    dreq = 1'b1; dhit = 1'b0;
    cyc();
    cyc();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_cmp++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL wd_early w%0d got %b want 0", k, timeout); end
      cyc();
    end
    @(negedge clk);
    n_cmp++; if (timeout !== 1'b1) begin n_fail++; $display("FAIL wd_set got %b want 1", timeout); end
    n_cmp++; if ({mem_req, pc_write} !== 2'b00) begin n_fail++; $display("FAIL wd_no_retry got %b want 00", {mem_req, pc_write}); end
    n_cmp++; if (s_timeout !== 1'b0) begin n_fail++; $display("FAIL wd_long_timeout got %b want 0", s_timeout); end
    ack = 1'b1;
    cyc();
    ack = 1'b0;
    @(negedge clk);
    n_cmp++; if ({refill_we, timeout} !== 2'b11) begin n_fail++; $display("FAIL wd_sticky got %b want 11", {refill_we, timeout}); end
    cyc();
    idle_inputs();
  endtask

  task automatic test_saturation;
    apply_reset();
    for (int m = 0; m < 9; m++) begin
      dreq = 1'b1; dhit = 1'b0; ack = 1'b0;
      cyc();
      ack = 1'b1;
      cyc();
      ack = 1'b0;
      cyc();
    end
    idle_inputs();
    @(negedge clk);
    n_cmp++; if (s_miss_cnt !== 3'd7) begin n_fail++; $display("FAIL sat_miss_cnt got %0d want 7", s_miss_cnt); end
    n_cmp++; if (s_stall_cnt !== 3'd7) begin n_fail++; $display("FAIL sat_stall_cnt got %0d want 7", s_stall_cnt); end
    n_cmp++; if (miss_cnt !== 16'd9) begin n_fail++; $display("FAIL wide_miss_cnt got %0d want 9", miss_cnt); end
    n_cmp++; if (stall_cnt !== 16'd27) begin n_fail++; $display("FAIL wide_stall_cnt got %0d want 27", stall_cnt); end
    n_cmp++; if (s_pc_write !== 1'b1) begin n_fail++; $display("FAIL sat_resume_pc got %b want 1", s_pc_write); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch_flush();
    test_miss_3cycle();
    test_fast_ack();
    test_miss_priority();
    test_watchdog();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
